// File: rtl/router_pkg.sv
// Shared types and default geometry for the router data/parity register stage.
package router_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_LEN_W     = DEF_DATA_W - DEF_ADDR_W;

  // Header byte layout: length in the upper bits, destination in the lower bits.
  typedef struct packed {
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_ADDR_W-1:0] addr;
  } hdr_t;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } fsm_state_t;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity accumulator; with ROUTER_LEN_CHECK_EN it also keeps a
// saturating count of payload bytes.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
`ifdef ROUTER_LEN_CHECK_EN
  ,
  parameter int LEN_W  = DEF_LEN_W
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
`ifdef ROUTER_LEN_CHECK_EN
  input  logic              cnt_en,
  output logic [LEN_W-1:0]  byte_cnt,
`endif
  output logic [DATA_W-1:0] parity
);

  always_ff @(posedge clock) begin
    if (!resetn || clr) begin
      parity   <= '0;
`ifdef ROUTER_LEN_CHECK_EN
      byte_cnt <= '0;
`endif
    end else if (en) begin
      parity <= parity ^ din;
`ifdef ROUTER_LEN_CHECK_EN
      // Saturate so an over-long packet can never wrap back to a legal length.
      if (cnt_en && byte_cnt != '1) byte_cnt <= byte_cnt + LEN_W'(1);
`endif
    end
  end

endmodule

// File: rtl/router_reg_param.sv
// Router data/parity register stage: header latch, FIFO write data, full-hold
// byte, parity/address/length checks. Optional length check: ROUTER_LEN_CHECK_EN.
module router_reg_param
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int LEN_W     = DATA_W - ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              addr_err,
  output logic              len_err
);

  localparam logic [ADDR_W:0] PORTS_LIM = (ADDR_W+1)'(NUM_PORTS);

  logic [DATA_W-1:0] header_reg, hold_reg, pkt_parity, int_parity, acc_din;
  logic              done_q, hdr_acc, hdr_fold, ld_pay, ld_par, byte_fold, parity_chk;

  assign hdr_acc    = detect_add && pkt_valid;
  assign hdr_fold   = !detect_add && lfd_state;
  assign ld_pay     = !detect_add && !lfd_state && ld_state && pkt_valid;
  assign ld_par     = !detect_add && !lfd_state && ld_state && !pkt_valid;
  // A byte parked by fifo_full is folded when first seen in LOAD_DATA, never on replay.
  assign byte_fold  = ld_pay && !full_state;
  assign acc_din    = hdr_fold ? header_reg : data_in;
  assign parity_chk = parity_done && !done_q;

`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0] byte_cnt;
`endif

  router_parity_acc #(
    .DATA_W (DATA_W)
`ifdef ROUTER_LEN_CHECK_EN
    ,
    .LEN_W  (LEN_W)
`endif
  ) u_acc (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (hdr_acc),
    .en       (hdr_fold || byte_fold),
    .din      (acc_din),
`ifdef ROUTER_LEN_CHECK_EN
    .cnt_en   (byte_fold),
    .byte_cnt (byte_cnt),
`endif
    .parity   (int_parity)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_reg    <= '0;
      hold_reg      <= '0;
      pkt_parity    <= '0;
      dout          <= '0;
      parity_done   <= 1'b0;
      done_q        <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      addr_err      <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
      len_err       <= 1'b0;
`endif
    end else begin
      done_q <= parity_done;
      // Checks resolve once, the cycle after parity_done rises; a header accept below wins.
      if (parity_chk) begin
        err <= (int_parity != pkt_parity);
`ifdef ROUTER_LEN_CHECK_EN
        len_err <= (byte_cnt != LEN_W'(header_reg[DATA_W-1:ADDR_W]));
`endif
      end

      if (detect_add) begin
        if (pkt_valid) begin
          header_reg  <= data_in;
          pkt_parity  <= '0;
          parity_done <= 1'b0;
          err         <= 1'b0;
          addr_err    <= ({1'b0, data_in[ADDR_W-1:0]} >= PORTS_LIM);
`ifdef ROUTER_LEN_CHECK_EN
          len_err     <= 1'b0;
`endif
        end
      end else if (lfd_state) begin
        dout <= header_reg;
      end else if (ld_state) begin
        if (pkt_valid) begin
          if (fifo_full) hold_reg <= data_in;
          else           dout     <= data_in;
        end else begin
          pkt_parity <= data_in;
          if (!fifo_full) begin
            dout        <= data_in;
            parity_done <= 1'b1;
          end
        end
      end else if (laf_state) begin
        dout <= hold_reg;
        if (low_pkt_valid) parity_done <= 1'b1;
      end

      if (rst_int_reg)  low_pkt_valid <= 1'b0;
      else if (ld_par)  low_pkt_valid <= 1'b1;
    end
  end

`ifndef ROUTER_LEN_CHECK_EN
  assign len_err = 1'b0;
  // LEN_W only shapes the length check; referenced here so both builds elaborate alike.
  if (LEN_W > 0) begin : g_no_len_check
  end
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// Scoreboard bench for router_reg_param: the driver plays the router FSM and
// queues cycle-stamped expectations; a negedge monitor pops and compares them.
module tb_router_reg_param;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in, dout;
  logic       parity_done, low_pkt_valid, err, addr_err, len_err;

  router_reg_param #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3)) dut (
    .clock(clock), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .addr_err(addr_err), .len_err(len_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum int {K_DOUT, K_PDONE, K_LPV, K_ERR, K_AERR, K_LERR} kind_t;
  typedef struct {
    int         cyc;
    kind_t      kind;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pl_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic void compare(exp_t e);
    logic [7:0] a;
    string      nm;
    case (e.kind)
      K_DOUT:  begin a = dout;                  nm = "dout";          end
      K_PDONE: begin a = {7'b0, parity_done};   nm = "parity_done";   end
      K_LPV:   begin a = {7'b0, low_pkt_valid}; nm = "low_pkt_valid"; end
      K_ERR:   begin a = {7'b0, err};           nm = "err";           end
      K_AERR:  begin a = {7'b0, addr_err};      nm = "addr_err";      end
      default: begin a = {7'b0, len_err};       nm = "len_err";       end
    endcase
    checks++;
    if (a !== e.val) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, e.cyc, a, e.val);
    end
  endfunction

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end
  end

  task automatic expect_nxt(kind_t k, logic [7:0] v);
    exp_t e;
    e.cyc = cyc + 1; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; data_in = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] good_parity(logic [7:0] hdr);
    logic [7:0] x = hdr;
    foreach (pl_q[i]) x ^= pl_q[i];
    return x;
  endfunction

  // Drives one packet from pl_q; expectations come from the packet-level rules.
  task automatic send_pkt(logic [7:0] hdr, logic [7:0] par, int full_idx, bit ri, int hold_cycles);
    logic [7:0] last;
    int         cnt;
    bit         e_err, e_len, e_aerr;
    e_err  = (good_parity(hdr) != par);
    cnt    = (pl_q.size() > 63) ? 63 : pl_q.size();
`ifdef ROUTER_LEN_CHECK_EN
    e_len  = (cnt != int'(hdr[7:2]));
`else
    e_len  = 1'b0;
`endif
    e_aerr = (hdr[1:0] >= 2'd3);

    idle(); detect_add = 1; pkt_valid = 1; data_in = hdr;
    expect_nxt(K_AERR, {7'b0, e_aerr}); expect_nxt(K_ERR, 8'h00);
    expect_nxt(K_PDONE, 8'h00); expect_nxt(K_LERR, 8'h00);
    tick();
    idle(); lfd_state = 1; pkt_valid = 1;
    expect_nxt(K_DOUT, hdr);
    tick();
    last = hdr;
    foreach (pl_q[i]) begin
      idle(); ld_state = 1; pkt_valid = 1; data_in = pl_q[i];
      if (i == full_idx) begin
        fifo_full = 1; expect_nxt(K_DOUT, last);
        tick();
        idle(); full_state = 1; fifo_full = 1; pkt_valid = 1; data_in = pl_q[i];
        expect_nxt(K_DOUT, last);
        tick();
        idle(); laf_state = 1; pkt_valid = 1;
        expect_nxt(K_DOUT, pl_q[i]); expect_nxt(K_PDONE, 8'h00);
        tick();
      end else begin
        expect_nxt(K_DOUT, pl_q[i]);
        tick();
      end
      last = pl_q[i];
    end
    idle(); ld_state = 1; data_in = par; rst_int_reg = ri;
    expect_nxt(K_DOUT, par); expect_nxt(K_PDONE, 8'h01);
    expect_nxt(K_LPV, ri ? 8'h00 : 8'h01); expect_nxt(K_ERR, 8'h00);
    tick();
    idle(); rst_int_reg = 1;
    expect_nxt(K_LPV, 8'h00); expect_nxt(K_PDONE, 8'h01);
    tick();
    idle();
    expect_nxt(K_ERR, {7'b0, e_err}); expect_nxt(K_LERR, {7'b0, e_len});
    tick();
    // Flags hold through idle, including detect_add without pkt_valid.
    for (int k = 0; k < hold_cycles; k++) begin
      idle(); detect_add = 1'($urandom);
      expect_nxt(K_ERR, {7'b0, e_err}); expect_nxt(K_AERR, {7'b0, e_aerr});
      expect_nxt(K_PDONE, 8'h01); expect_nxt(K_LERR, {7'b0, e_len});
      tick();
    end
  endtask

  task automatic expect_all_zero();
    expect_nxt(K_DOUT, 8'h00); expect_nxt(K_PDONE, 8'h00); expect_nxt(K_LPV, 8'h00);
    expect_nxt(K_ERR, 8'h00);  expect_nxt(K_AERR, 8'h00);  expect_nxt(K_LERR, 8'h00);
  endtask

  initial begin
    hdr_t h;
    int   n, fi;
    logic [7:0] par;

    idle(); resetn = 0; ld_state = 1; pkt_valid = 1; data_in = 8'h5A;
    expect_all_zero();
    tick();
    resetn = 1; idle();
    tick();

    pl_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_pkt(8'h16, 8'hF7, -1, 1'b0, 1);
    pl_q = '{8'hA1, 8'hB2, 8'hC2, 8'hD4, 8'hE5};
    send_pkt(8'h16, 8'hF7, -1, 1'b0, 3);
    pl_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_pkt(8'h16, 8'hF7, 2, 1'b1, 1);
    send_pkt(8'h17, 8'hF6, -1, 1'b0, 1);
    send_pkt(8'h1A, 8'hFB, -1, 1'b0, 1);

    // Over-long packets: count saturates at 63.
    pl_q.delete();
    for (int i = 0; i < 70; i++) pl_q.push_back(8'($urandom));
    send_pkt(8'hFD, good_parity(8'hFD), 5, 1'b0, 1);
    send_pkt(8'hF9, good_parity(8'hF9), -1, 1'b1, 1);

    // Reset mid-packet after a failed packet leaves no residue.
    pl_q = '{8'hA1, 8'hB2, 8'hC2, 8'hD4, 8'hE5};
    send_pkt(8'h16, 8'hF7, -1, 1'b0, 1);
    idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h17; tick();
    idle(); lfd_state = 1; pkt_valid = 1; tick();
    idle(); ld_state = 1; pkt_valid = 1; data_in = 8'h33; tick();
    idle(); resetn = 0; ld_state = 1; data_in = 8'h44;
    expect_all_zero();
    tick();
    resetn = 1; idle(); tick();

    for (int p = 0; p < 40; p++) begin
      n = 1 + int'($urandom % 8);
      h.addr = 2'($urandom);
      h.len  = ($urandom % 3 == 0) ? 6'(n + 1) : 6'(n);
      pl_q.delete();
      for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
      par = good_parity(h);
      if ($urandom % 4 == 0) par = par ^ (8'h01 << ($urandom % 8));
      fi = ($urandom % 2 == 0) ? int'($urandom % n) : -1;
      send_pkt(h, par, fi, 1'($urandom), int'($urandom % 3));
      for (int g = int'($urandom % 3); g > 0; g--) begin idle(); tick(); end
    end

    idle();
    repeat (3) tick();
    foreach (sb[i]) begin
      checks++; errors++;
      $display("FAIL expired kind=%0d cyc=%0d got=none exp=%h", sb[i].kind, sb[i].cyc, sb[i].val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
Parametrised successor to the router data/parity register stage. It sits between the router FSM and the output FIFOs. It latches the header, drives packet bytes to the FIFO write path, and holds the byte that arrives while the FIFO is full. It computes running XOR parity, flags parity errors, and additionally validates the header address and the payload length. Data width, address-field width and port count are generic; the original stage had a fixed 8-bit/2-bit/3-port layout.

Parameters:
DATA_W, 8, width of data_in/dout and parity
ADDR_W, 2, header address field width (header[ADDR_W-1:0])
NUM_PORTS, 3, legal destinations are 0..NUM_PORTS-1; NUM_PORTS <= 2**ADDR_W
LEN_W, DATA_W-ADDR_W, header length field width (header[DATA_W-1:ADDR_W])

Ports:
clock  in  1  system clock, all logic on posedge
resetn  in  1  synchronous, active-low reset
data_in  in  DATA_W  header/payload/parity byte from source
pkt_valid  in  1  source packet valid; low marks the parity byte
fifo_full  in  1  addressed FIFO full
rst_int_reg  in  1  FSM clears low_pkt_valid
detect_add  in  1  FSM DECODE_ADDRESS state
lfd_state  in  1  FSM LOAD_FIRST_DATA
ld_state  in  1  FSM LOAD_DATA
laf_state  in  1  FSM LOAD_AFTER_FULL
full_state  in  1  FSM FIFO_FULL_STATE
dout  out  DATA_W  byte to FIFO write port
parity_done  out  1  parity byte captured
low_pkt_valid  out  1  pkt_valid dropped during load
err  out  1  parity mismatch, sticky
addr_err  out  1  header address >= NUM_PORTS, sticky
len_err  out  1  payload count != header length, sticky (see Optional Feature)

Behaviour:
- Reset (resetn=0 at posedge):
  - All outputs are 0.
  - header_reg, hold_reg, int_parity, pkt_parity and byte_cnt are 0.
- Reset overrides every other input. Reset in mid-packet abandons the packet with no residual flags.
- detect_add && pkt_valid:
  - header_reg <= data_in.
  - int_parity, pkt_parity, byte_cnt, parity_done, err and len_err clear.
  - addr_err <= (data_in[ADDR_W-1:0] >= NUM_PORTS).
- detect_add without pkt_valid: registers hold.
- lfd_state:
  - dout <= header_reg.
  - int_parity <= int_parity ^ header_reg.
- ld_state && pkt_valid:
  - !fifo_full: dout <= data_in.
  - fifo_full: hold_reg <= data_in; dout holds.
  - If !full_state: int_parity ^= data_in and byte_cnt++.
  - Each byte is counted and folded into parity exactly once.
  - byte_cnt is LEN_W bits and saturates at all-ones (no wrap).
- ld_state && !pkt_valid:
  - pkt_parity <= data_in.
  - low_pkt_valid <= 1.
  - If !fifo_full: dout <= data_in and parity_done <= 1.
- laf_state:
  - dout <= hold_reg.
  - If low_pkt_valid && !parity_done: parity_done <= 1.
- rst_int_reg: low_pkt_valid <= 0. It has priority over setting low_pkt_valid in the same cycle.
- Error timing: one cycle after parity_done first rises, err <= (int_parity != pkt_parity).
  - err is valid 2 cycles after the parity byte is sampled.
  - err holds until the next header accept or reset.
- Simultaneous state inputs are illegal. The priority order is detect_add > lfd > ld > laf.
- parity_done stays high until the next header accept.

Optional Feature:
ROUTER_LEN_CHECK_EN
- Defined: on the same cycle err updates, len_err <= (byte_cnt != header_reg[DATA_W-1:ADDR_W]). A saturated byte_cnt always mismatches unless the length field is all-ones.
- Undefined: byte_cnt logic is removed and len_err is tied to 0.

Decomposition:
- Package router_pkg holds:
  - the header field typedef (struct of len, addr) parametrised via DATA_W/ADDR_W localparams;
  - default width constants;
  - the FSM state enum shared with the router FSM.
- Sub-module router_parity_acc: XOR accumulator with clear, enable and byte_cnt, instantiated once.

Test Plan:
All cases use DATA_W=8, ADDR_W=2, NUM_PORTS=3.
1. Reset: resetn=0 with ld_state=1 and data_in=0x5A -> dout=0, all flags 0 at next posedge.
2. Clean packet:
   - Stimulus: header 0x16, payload A1 B2 C3 D4 E5, parity 0xF7 (XOR including header).
   - Response: dout mirrors each byte 1 cycle later; parity_done=1; err=0 two cycles after the parity byte; len_err=0.
3. Corrupt payload: payload[2]=0xC2, parity 0xF7 -> err=1; err stays 1 until the next header accept, then 0.
4. FIFO full:
   - Stimulus: fifo_full=1 while 0xC3 is driven; FSM goes full_state then laf_state.
   - Response: dout=0xC3 in laf; parity still 0xF7 with err=0, i.e. 0xC3 is folded into parity exactly once.
5. Bad header and length:
   - Header 0x17 (addr 3) -> addr_err=1.
   - Header 0x1A (len 6) with 5 payload bytes -> len_err=1 only with ROUTER_LEN_CHECK_EN, else 0.
6. low_pkt_valid:
   - ld_state=1 with pkt_valid=0 -> low_pkt_valid=1 next posedge.
   - rst_int_reg=1 -> 0 next posedge, including when asserted in the same cycle as the set.
